io_out_fifo_port: RTL and testbench

//   Output-port peripheral downstream of the IO port-address decoder. It is enabled

---
 rtl/io_out_fifo_port.sv | 89 ++++++++
 tb/tb_io_out_fifo_port.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/io_out_fifo_port.sv
// Decoder-selected output port: CPU writes push bytes into a small FIFO drained by
// an external consumer over valid/ready; CPU reads return a status byte on the bus.
module io_out_fifo_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] bus,
    input  logic       sel_x_n,
    input  logic       sel_y_n,
    input  logic       wrn,
    input  logic       rdn,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overflow
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wp_reg;
    logic [AW-1:0] rp_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;

    logic          sel;
    logic          push_req;
    logic          rd_req;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_ok;
    logic [4:0]    count_ext;
    logic [7:0]    status;

    assign sel      = ~sel_x_n & ~sel_y_n;
    assign push_req = sel & ~wrn;
    // A write strobe wins over a read strobe, so the bus is never contended.
    assign rd_req   = sel & ~rdn & wrn;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop     = ~empty & out_ready;
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign push_ok = push_req & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg       <= '0;
            rp_reg       <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wp_reg <= wp_reg + 1'b1;
            end
            if (pop) begin
                rp_reg <= rp_reg + 1'b1;
            end
            if (push_ok && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
            // A dropped byte sets the flag even if a status read clears it the same edge.
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (rd_req) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Storage carries no reset; stale entries are masked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp_reg] <= bus;
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? 8'h00 : mem[rp_reg];
    assign overflow  = overflow_reg;

    assign count_ext = 5'(count_reg);
    assign status    = {overflow_reg, full, empty, count_ext};
    assign bus       = rd_req ? status : 8'hzz;

endmodule

// File: tb/tb_io_out_fifo_port.sv
// Directed and randomized checks of io_out_fifo_port against a queue-based model
// of the port: FIFO order, drop-on-full, status byte, read-to-clear and reset.
module tb_io_out_fifo_port;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    wire  [7:0] bus;
    logic       sel_x_n = 1'b1;
    logic       sel_y_n = 1'b1;
    logic       wrn = 1'b1;
    logic       rdn = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overflow;

    logic       tb_drive = 1'b0;
    logic [7:0] tb_byte = 8'h00;

    // Undriven bus floats high, so 8'hFF stands for "nobody drives".
    // A real status byte can never be FF because full and empty are exclusive.
    pullup pu_bus (bus);
    assign bus = tb_drive ? tb_byte : 8'hzz;

    io_out_fifo_port #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sel_x_n   (sel_x_n),
        .sel_y_n   (sel_y_n),
        .wrn       (wrn),
        .rdn       (rdn),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] q [$];
    logic       m_ovf = 1'b0;
    logic [7:0] last_pop = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-10s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_status();
        logic [4:0] cnt;
        cnt = 5'(q.size());
        return {m_ovf, q.size() == DEPTH, q.size() == 0, cnt};
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, q.size() != 0});
        check({tag, ".data"}, out_data, (q.size() != 0) ? q[0] : 8'h00);
        check({tag, ".ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
    endtask

    // One bus cycle: drive strobes, check the bus mid-cycle, clock, update model, check.
    task automatic cyc(input logic sx, input logic sy, input logic w, input logic r,
                       input logic rdy, input logic [7:0] d, input string tag);
        logic sel, push, rdq, pop, accept;
        sel_x_n   = sx;
        sel_y_n   = sy;
        wrn       = w;
        rdn       = r;
        out_ready = rdy;
        tb_byte   = d;
        tb_drive  = ~w;
        #1;
        sel  = ~sx & ~sy;
        push = sel & ~w;
        rdq  = sel & ~r & w;
        if (rdq) begin
            check({tag, ".status"}, bus, model_status());
        end else if (w) begin
            check({tag, ".bus_z"}, bus, 8'hFF);
        end
        pop    = (q.size() != 0) && rdy;
        accept = push && ((q.size() < DEPTH) || pop);
        @(posedge clk);
        if (pop) begin
            last_pop = q.pop_front();
        end
        if (accept) begin
            q.push_back(d);
        end
        if (push && !accept) begin
            m_ovf = 1'b1;
        end else if (rdq) begin
            m_ovf = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input logic rdy, input string tag);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, rdy, 8'h00, tag);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic rdy, input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, rdy, d, tag);
    endtask

    task automatic read_status(input string tag);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, tag);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", {7'd0, out_valid}, 8'h00);
        check("rst.ovf", {7'd0, overflow}, 8'h00);
        check("rst.data", out_data, 8'h00);
        check("rst.bus_z", bus, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        read_status("rst_read");

        // Single push latency
        push_byte(8'hA5, 1'b0, "push_a5");
        read_status("st_a5");
        idle(1'b1, "pop_a5");
        check("pop_a5.byte", last_pop, 8'hA5);

        // Fill past full: 55 is dropped
        push_byte(8'h11, 1'b0, "fill");
        push_byte(8'h22, 1'b0, "fill");
        push_byte(8'h33, 1'b0, "fill");
        push_byte(8'h44, 1'b0, "fill");
        push_byte(8'h55, 1'b0, "drop");
        // Push while full with a simultaneous pop
        push_byte(8'h66, 1'b1, "full_pp");
        check("full_pp.pop", last_pop, 8'h11);
        // Deselected read (sel_y_n high): bus floats, no clear
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "desel_rd");
        // Read-to-clear
        read_status("clr_read");
        // Both strobes: write wins, bus not driven by DUT
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, "wr_and_rd");
        repeat (4) idle(1'b1, "drain");
        check("drain.last", last_pop, 8'h77);

        // Asynchronous reset mid-drain with three entries
        push_byte(8'hB1, 1'b0, "pre_rst");
        push_byte(8'hB2, 1'b0, "pre_rst");
        push_byte(8'hB3, 1'b0, "pre_rst");
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid", {7'd0, out_valid}, 8'h00);
        check("arst.data", out_data, 8'h00);
        q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1'b0, "post_rst");

        // Pointer wrap: push/pop pairs
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(8'hC0 + i), 1'b0, "wrap_push");
            idle(1'b1, "wrap_pop");
            check("wrap.order", last_pop, 8'(8'hC0 + i));
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic sx, sy, w, r, rdy;
            sx  = ($urandom_range(0, 4) == 0);
            sy  = ($urandom_range(0, 4) == 0);
            w   = $urandom_range(0, 1) == 1;
            r   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            cyc(sx, sy, w, r, rdy, 8'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
